// File: rtl/vregfile_seq_pkg.sv
// ============================================================================
// Module  : vregfile_seq_pkg
// Brief   : Shared types for the vector register file port sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package vregfile_seq_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_A     = 3'd1,
        RD_B     = 3'd2,
        ISSUE    = 3'd3,
        WAIT_RES = 3'd4,
        WB       = 3'd5
    } vrf_seq_state_e;

    // Requester slots on the round-robin arbiter.
    localparam int unsigned REQ_OP  = 0;
    localparam int unsigned REQ_LSU = 1;

endpackage : vregfile_seq_pkg

`default_nettype wire

// File: rtl/vregfile_seq_rr_arb.sv
// ============================================================================
// Module  : vrf_rr_arb2
// Brief   : Two-way round-robin arbiter; prio flop favours req[1] when set.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vrf_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic prio_q;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i[0] && req_i[1]) begin
                gnt_o = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
    end

    // Whoever wins yields priority to the other side next time.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= 1'b0;
        end else if (gnt_o != 2'b00) begin
            prio_q <= gnt_o[0];
        end
    end

endmodule : vrf_rr_arb2

`default_nettype wire

// File: rtl/vregfile_seq.sv
// ============================================================================
// Module  : vregfile_seq
// Brief   : Shares the single vregfile port between the ALU op path and LSU.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module vregfile_seq
    import vregfile_seq_pkg::*;
#(
    parameter int unsigned DataWidth = 128,
    parameter int unsigned AddrWidth = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 op_valid_i,
    output logic                 op_ready_o,
    input  logic [AddrWidth-1:0] op_vs1_i,
    input  logic [AddrWidth-1:0] op_vs2_i,
    input  logic [AddrWidth-1:0] op_vd_i,
    output logic                 alu_valid_o,
    input  logic                 alu_ready_i,
    output logic [DataWidth-1:0] alu_a_o,
    output logic [DataWidth-1:0] alu_b_o,
    input  logic                 res_valid_i,
    output logic                 res_ready_o,
    input  logic [DataWidth-1:0] res_data_i,
    input  logic                 lsu_req_i,
    output logic                 lsu_gnt_o,
    input  logic                 lsu_we_i,
    input  logic [AddrWidth-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_rvalid_o,
    output logic [DataWidth-1:0] lsu_rdata_o,
    output logic                 busy_o,
    output logic                 vrf_we_o,
    output logic [AddrWidth-1:0] vrf_addr_o,
    output logic [DataWidth-1:0] vrf_wdata_o,
    input  logic [DataWidth-1:0] vrf_rdata_i
);

    vrf_seq_state_e state_q, state_d;

    logic [AddrWidth-1:0] vs1_q, vs2_q, vd_q;
    logic [DataWidth-1:0] res_q;
    logic [DataWidth-1:0] alu_a_q, alu_b_q;
    logic [DataWidth-1:0] lsu_rdata_q;
    logic                 lsu_rvalid_q;

    logic [1:0] arb_req, arb_gnt;
    logic       arb_en;
    logic       op_win, lsu_win;

    assign arb_req[REQ_OP]  = op_valid_i;
    assign arb_req[REQ_LSU] = lsu_req_i;
    // Gating with rst_ni keeps every handshake low while reset is held.
    assign arb_en  = (state_q == IDLE) && rst_ni;
    assign op_win  = arb_gnt[REQ_OP];
    assign lsu_win = arb_gnt[REQ_LSU];

    vrf_rr_arb2 u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (arb_en),
        .req_i  (arb_req),
        .gnt_o  (arb_gnt)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_ready_o  = 1'b0;
        lsu_gnt_o   = 1'b0;
        alu_valid_o = 1'b0;
        res_ready_o = 1'b0;
        vrf_we_o    = 1'b0;
        vrf_addr_o  = '0;
        vrf_wdata_o = '0;
        unique case (state_q)
            IDLE: begin
                op_ready_o = op_win;
                lsu_gnt_o  = lsu_win;
                if (lsu_win) begin
                    vrf_we_o    = lsu_we_i;
                    vrf_addr_o  = lsu_addr_i;
                    vrf_wdata_o = lsu_wdata_i;
                end
                if (op_win) begin
                    state_d = RD_A;
                end
            end
            RD_A: begin
                vrf_addr_o = vs1_q;
                state_d    = RD_B;
            end
            RD_B: begin
                vrf_addr_o = vs2_q;
                state_d    = ISSUE;
            end
            ISSUE: begin
                alu_valid_o = 1'b1;
                if (alu_ready_i) begin
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                res_ready_o = 1'b1;
                if (res_valid_i) begin
                    state_d = WB;
                end
            end
            WB: begin
                vrf_we_o    = 1'b1;
                vrf_addr_o  = vd_q;
                vrf_wdata_o = res_q;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vs1_q        <= '0;
            vs2_q        <= '0;
            vd_q         <= '0;
            res_q        <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            lsu_rdata_q  <= '0;
            lsu_rvalid_q <= 1'b0;
        end else begin
            lsu_rvalid_q <= lsu_win && !lsu_we_i;
            if (lsu_win && !lsu_we_i) begin
                lsu_rdata_q <= vrf_rdata_i;
            end
            if (op_win) begin
                vs1_q <= op_vs1_i;
                vs2_q <= op_vs2_i;
                vd_q  <= op_vd_i;
            end
            if (state_q == RD_A) begin
                alu_a_q <= vrf_rdata_i;
            end
            if (state_q == RD_B) begin
                alu_b_q <= vrf_rdata_i;
            end
            if ((state_q == WAIT_RES) && res_valid_i) begin
                res_q <= res_data_i;
            end
        end
    end

    assign alu_a_o      = alu_a_q;
    assign alu_b_o      = alu_b_q;
    assign lsu_rdata_o  = lsu_rdata_q;
    assign lsu_rvalid_o = lsu_rvalid_q;
    assign busy_o       = (state_q != IDLE);

endmodule : vregfile_seq

`default_nettype wire

// File: tb/tb_vregfile_seq.sv
// ============================================================================
// Module  : tb_vregfile_seq
// Brief   : Self-checking bench for vregfile_seq with vregfile and ALU models.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vregfile_seq;

    localparam int DW = 128;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          op_valid, op_ready;
    logic [AW-1:0] op_vs1, op_vs2, op_vd;
    logic          alu_valid, alu_ready;
    logic [DW-1:0] alu_a, alu_b;
    logic          res_valid, res_ready;
    logic [DW-1:0] res_data;
    logic          lsu_req, lsu_gnt, lsu_we;
    logic [AW-1:0] lsu_addr;
    logic [DW-1:0] lsu_wdata;
    logic          lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic          busy, vrf_we;
    logic [AW-1:0] vrf_addr;
    logic [DW-1:0] vrf_wdata, vrf_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int alu_stall = 0;
    int res_delay = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vregfile_seq dut (
        .clk_i(clk), .rst_ni(rst_n),
        .op_valid_i(op_valid), .op_ready_o(op_ready),
        .op_vs1_i(op_vs1), .op_vs2_i(op_vs2), .op_vd_i(op_vd),
        .alu_valid_o(alu_valid), .alu_ready_i(alu_ready),
        .alu_a_o(alu_a), .alu_b_o(alu_b),
        .res_valid_i(res_valid), .res_ready_o(res_ready), .res_data_i(res_data),
        .lsu_req_i(lsu_req), .lsu_gnt_o(lsu_gnt), .lsu_we_i(lsu_we),
        .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata),
        .lsu_rvalid_o(lsu_rvalid), .lsu_rdata_o(lsu_rdata),
        .busy_o(busy),
        .vrf_we_o(vrf_we), .vrf_addr_o(vrf_addr), .vrf_wdata_o(vrf_wdata),
        .vrf_rdata_i(vrf_rdata)
    );

    // Register file: combinational read, synchronous write.
    logic [DW-1:0] vrf_mem [32];
    bit            mem_init = 1'b0;
    assign vrf_rdata = vrf_mem[vrf_addr];
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 32; i++) vrf_mem[i] <= '0;
            mem_init <= 1'b1;
        end else if (vrf_we) begin
            vrf_mem[vrf_addr] <= vrf_wdata;
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout cyc=%0d", name, cyc);
    endtask

    // ALU: adds its operands, with programmable ready stall and result delay.
    initial begin
        int sc, wc;
        logic [DW-1:0] hold;
        sc = 0; wc = 0; hold = '0;
        alu_ready = 1'b0; res_valid = 1'b0; res_data = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                alu_ready = 1'b0; res_valid = 1'b0; sc = 0; wc = 0;
            end else begin
                if (alu_valid) begin
                    if (sc < alu_stall) begin alu_ready = 1'b0; sc++; end
                    else begin alu_ready = 1'b1; hold = alu_a + alu_b; end
                end else begin
                    alu_ready = 1'b0; sc = 0;
                end
                if (res_ready) begin
                    if (wc < res_delay) begin res_valid = 1'b0; wc++; end
                    else begin res_valid = 1'b1; res_data = hold; end
                end else begin
                    res_valid = 1'b0; wc = 0;
                end
            end
        end
    end

    // Transaction-level reference: register contents, arbitration fairness,
    // and op timing measured from acceptance and handshake cycles.
    logic [DW-1:0] shadow [32] = '{default: '0};
    bit            m_prio = 1'b0;
    bit            op_act = 1'b0;
    int            t_acc, t_iss, t_res;
    logic [AW-1:0] m_vd;
    logic [DW-1:0] m_a, m_b;
    bit            rd_pend = 1'b0;
    logic [DW-1:0] rd_exp;

    always @(negedge clk) begin
        bit ow, lw, exp_av, exp_rr, exp_wb;
        if (!rst_n) begin
            op_act = 1'b0; m_prio = 1'b0; rd_pend = 1'b0;
        end else begin
            chk("lsu_rvalid", {127'd0, lsu_rvalid}, {127'd0, rd_pend});
            if (rd_pend) chk("lsu_rdata", lsu_rdata, rd_exp);
            rd_pend = 1'b0;
            chk("busy", {127'd0, busy}, {127'd0, op_act});
            if (!op_act) begin
                ow = op_valid && (!lsu_req || !m_prio);
                lw = lsu_req && (!op_valid || m_prio);
                chk("op_ready", {127'd0, op_ready}, {127'd0, ow});
                chk("lsu_gnt", {127'd0, lsu_gnt}, {127'd0, lw});
                chk("alu_valid_idle", {127'd0, alu_valid}, '0);
                chk("res_ready_idle", {127'd0, res_ready}, '0);
                if (lw) begin
                    chk("lsu_vrf_we", {127'd0, vrf_we}, {127'd0, lsu_we});
                    chk("lsu_vrf_addr", {123'd0, vrf_addr}, {123'd0, lsu_addr});
                    if (lsu_we) begin
                        chk("lsu_vrf_wdata", vrf_wdata, lsu_wdata);
                        shadow[lsu_addr] = lsu_wdata;
                    end else begin
                        rd_pend = 1'b1;
                        rd_exp  = shadow[lsu_addr];
                    end
                    m_prio = 1'b0;
                end else begin
                    chk("idle_vrf_we", {127'd0, vrf_we}, '0);
                end
                if (ow) begin
                    op_act = 1'b1; t_acc = cyc; t_iss = -1; t_res = -1;
                    m_a = shadow[op_vs1]; m_b = shadow[op_vs2]; m_vd = op_vd;
                    m_prio = 1'b1;
                end
            end else begin
                exp_av = (cyc >= t_acc + 3) && (t_iss < 0);
                exp_rr = (t_iss >= 0) && (t_res < 0);
                exp_wb = (t_res >= 0) && (cyc == t_res + 1);
                chk("op_ready_busy", {127'd0, op_ready}, '0);
                chk("lsu_gnt_busy", {127'd0, lsu_gnt}, '0);
                chk("alu_valid", {127'd0, alu_valid}, {127'd0, exp_av});
                chk("res_ready", {127'd0, res_ready}, {127'd0, exp_rr});
                if (exp_av) begin
                    chk("alu_a", alu_a, m_a);
                    chk("alu_b", alu_b, m_b);
                end
                chk("op_vrf_we", {127'd0, vrf_we}, {127'd0, exp_wb});
                if (exp_wb) begin
                    chk("wb_addr", {123'd0, vrf_addr}, {123'd0, m_vd});
                    chk("wb_data", vrf_wdata, m_a + m_b);
                    shadow[m_vd] = m_a + m_b;
                    op_act = 1'b0;
                end
                if (exp_av && alu_ready) t_iss = cyc;
                if (exp_rr && res_valid) t_res = cyc;
            end
        end
    end

    task automatic do_op(input logic [AW-1:0] a, b, d, output int tacc);
        bit got;
        got = 1'b0; tacc = -1;
        op_valid = 1'b1; op_vs1 = a; op_vs2 = b; op_vd = d;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (op_ready) begin got = 1'b1; tacc = cyc; end
        end
        if (!got) timeout("op_accept");
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic do_lsu(input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, output int tg);
        bit got;
        got = 1'b0; tg = -1;
        lsu_req = 1'b1; lsu_we = we; lsu_addr = addr; lsu_wdata = data;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (lsu_gnt) begin got = 1'b1; tg = cyc; end
        end
        if (!got) timeout("lsu_gnt");
        @(posedge clk); #1;
        lsu_req = 1'b0;
    endtask

    // Issues a read and checks the returned beat on the following cycle.
    task automatic lsu_read_check(input string name, input logic [AW-1:0] addr,
                                  input logic [DW-1:0] exp);
        int tg;
        do_lsu(1'b0, addr, '0, tg);
        @(negedge clk);
        chk({name, "_rvalid"}, {127'd0, lsu_rvalid}, {127'd0, 1'b1});
        chk({name, "_rdata"}, lsu_rdata, exp);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    initial begin
        int t0, t1, g0, g1, g2, ta, gb;
        bit seen;
        rst_n = 1'b0;
        op_valid = 1'b0; op_vs1 = '0; op_vs2 = '0; op_vd = '0;
        lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {127'd0, busy}, '0);
        chk("rst_vrf_we", {127'd0, vrf_we}, '0);
        chk("rst_alu_a", alu_a, '0);
        chk("rst_lsu_rdata", lsu_rdata, '0);
        chk("rst_lsu_rvalid", {127'd0, lsu_rvalid}, '0);

        // Both requesters high out of reset: op first, then alternate.
        fork
            begin
                do_op(5'd10, 5'd11, 5'd12, t0);
                do_op(5'd10, 5'd11, 5'd12, t1);
            end
            begin
                do_lsu(1'b1, 5'd1, {16{8'h11}}, g0);
                do_lsu(1'b1, 5'd2, {16{8'h22}}, g1);
                do_lsu(1'b1, 5'd13, {16{8'h77}}, g2);
            end
            begin
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
        join
        chk("arb_lsu_after_op", g0 - t0, 6);
        chk("arb_op_after_lsu", t1 - g0, 1);
        chk("arb_lsu_second", g1 - t1, 6);
        chk("arb_lsu_alone", g2 - g1, 1);
        wait_idle();

        // v1 + v2 -> v3 with operand timing.
        do_op(5'd1, 5'd2, 5'd3, ta);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (alu_valid) begin
                seen = 1'b1;
                chk("t1_issue_lat", cyc - ta, 3);
                chk("t1_alu_a", alu_a, {16{8'h11}});
                chk("t1_alu_b", alu_b, {16{8'h22}});
            end
        end
        if (!seen) timeout("t1_alu_valid");
        wait_idle();
        chk("t1_v3_mem", vrf_mem[3], {16{8'h33}});
        lsu_read_check("t1_v3", 5'd3, {16{8'h33}});

        // Back-to-back LSU write then read.
        do_lsu(1'b1, 5'd5, 128'hAB, g0);
        do_lsu(1'b0, 5'd5, '0, g1);
        chk("t3_b2b_gnt", g1 - g0, 1);
        @(negedge clk);
        chk("t3_rvalid", {127'd0, lsu_rvalid}, {127'd0, 1'b1});
        chk("t3_rdata", lsu_rdata, 128'hAB);
        @(posedge clk); #1;

        // All operands on the same register.
        do_lsu(1'b1, 5'd7, 128'h5, g0);
        do_op(5'd7, 5'd7, 5'd7, ta);
        wait_idle();
        lsu_read_check("t4_v7", 5'd7, 128'hA);

        // ALU stalls with an LSU request pending throughout.
        alu_stall = 4; res_delay = 3;
        do_op(5'd1, 5'd2, 5'd6, ta);
        do_lsu(1'b0, 5'd6, '0, gb);
        chk("t5_lsu_wait", gb - ta, 13);
        @(negedge clk);
        chk("t5_rdata", lsu_rdata, {16{8'h33}});
        @(posedge clk); #1;
        alu_stall = 0; res_delay = 0;

        // Reset while waiting on the result.
        res_delay = 20;
        do_op(5'd1, 5'd2, 5'd9, ta);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (res_ready) seen = 1'b1;
        end
        if (!seen) timeout("t6_res_ready");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_busy", {127'd0, busy}, '0);
        chk("t6_res_ready", {127'd0, res_ready}, '0);
        chk("t6_vrf_we", {127'd0, vrf_we}, '0);
        chk("t6_alu_a", alu_a, '0);
        chk("t6_alu_b", alu_b, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        res_delay = 0;
        chk("t6_idle_after", {127'd0, busy}, '0);
        chk("t6_v9_mem", vrf_mem[9], '0);
        lsu_read_check("t6_v9", 5'd9, '0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog global timeout");
        $fatal(1, "watchdog");
    end

endmodule : tb_vregfile_seq

`default_nettype wire
